// File: rtl/boot_loader.sv
// boot_loader: parses SYNC/ADDR/LEN/DATA/CSUM byte frames into boot-port memory writes
module boot_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         ADDR_W    = 13,
    parameter int         TIMEOUT   = 50000,
    parameter int         TO_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              debug,
    output logic [ADDR_W-1:0] boot_addr,
    output logic [7:0]        boot_data,
    output logic              boot_busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA, CSUM} state_t;
    state_t            state_q, state_d;
    logic              rdy_q;
    logic [7:0]        hi_q, hi_d, sum_q, sum_d, bdata_q, bdata_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, baddr_q, baddr_d;
    logic [15:0]       rem_q, rem_d, field;
    logic [16:0]       span_end;
    logic [TO_W-1:0]   to_q, to_d;
    logic              debug_q, debug_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              accept, abort;
    assign accept    = rx_valid & rdy_q;
    assign field     = {hi_q, rx_data};
    assign span_end  = 17'(ptr_q) + 17'(field);
    assign rx_ready  = rdy_q;
    assign debug     = debug_q;
    assign boot_addr = baddr_q;
    assign boot_data = bdata_q;
    assign boot_busy = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        sum_d   = sum_q;
        to_d    = to_q;
        debug_d = 1'b0;
        baddr_d = baddr_q;
        bdata_d = bdata_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        abort   = 1'b0;
        if (accept) begin
            to_d = '0;
            case (state_q)
                IDLE: if (rx_data == SYNC_BYTE) begin
                    state_d = ADDR_H;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    sum_d   = '0;
                    busy_d  = 1'b1;
                end
                ADDR_H: begin
                    hi_d    = rx_data;
                    state_d = ADDR_L;
                end
                ADDR_L: begin
                    ptr_d   = ADDR_W'(field);
                    abort   = |(field >> ADDR_W);
                    state_d = LEN_H;
                end
                LEN_H: begin
                    hi_d    = rx_data;
                    state_d = LEN_L;
                end
                LEN_L: begin
                    rem_d   = field;
                    abort   = (field == 16'd0) || (span_end > 17'(2 ** ADDR_W));
                    state_d = DATA;
                end
                DATA: begin
                    debug_d = 1'b1;
                    baddr_d = ptr_q;
                    bdata_d = rx_data;
                    ptr_d   = ptr_q + 1'b1;
                    rem_d   = rem_q - 16'd1;
                    sum_d   = sum_q + rx_data;
                    state_d = (rem_q == 16'd1) ? CSUM : DATA;
                end
                CSUM: begin
                    done_d  = rx_data == sum_q;
                    err_d   = rx_data != sum_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            abort = to_q == TO_W'(TIMEOUT - 1);
            to_d  = to_q + 1'b1;
        end
        // abort overrides whatever the accepted byte would have done, so it issues no write
        if (abort) begin
            state_d = IDLE;
            err_d   = 1'b1;
            done_d  = 1'b0;
            busy_d  = 1'b0;
            debug_d = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            hi_q    <= '0;
            ptr_q   <= '0;
            rem_q   <= '0;
            sum_q   <= '0;
            to_q    <= '0;
            debug_q <= 1'b0;
            baddr_q <= '0;
            bdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            hi_q    <= hi_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            sum_q   <= sum_d;
            to_q    <= to_d;
            debug_q <= debug_d;
            baddr_q <= baddr_d;
            bdata_q <= bdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule
